// File: rtl/tx_ctrl_arb.sv
// Round-robin arbiter and sequencer sharing one tx_ctrl frame path among
// NREQ requesters: pick a winner, latch its frame fields, fire now_send,
// wait for frame_done or timeout, report done/err, then hold an idle gap.
//
// state | meaning
// IDLE  | arbitrate among active requests, latch winner's fields
// LATCH | grant and fields valid for one cycle
// SEND  | now_send high for this cycle, wait counter cleared
// WAIT  | count cycles until frame_done or TMO-1
// GAP   | grant dropped, count GAP cycles before returning to IDLE
module tx_ctrl_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 4096,
  parameter int GAP  = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_dev_id,
  input  logic [8*NREQ-1:0]    req_mod_id,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic                 frame_done,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 now_send,
  output logic [7:0]           dev_id,
  output logic [7:0]           mod_id,
  output logic [7:0]           addr,
  output logic [7:0]           data,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [19:0] TMO_LAST = 20'(TMO - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SEND, S_WAIT, S_GAP} state_t;

  state_t          state;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] gnt_next;
  logic [19:0]     wcnt;
  logic [7:0]      gcnt;
  logic [7:0]      sel_dev, sel_mod, sel_addr, sel_data;

  // Winner search: walk downward in distance so the nearest set bit above rr wins.
  always_comb begin
    int cand;
    cand = 0;
    win  = rr;
    for (int i = NREQ; i >= 1; i--) begin
      cand = int'(rr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[PW'(cand)]) win = PW'(cand);
    end
  end

  // One-hot grant and field mux for the current winner.
  always_comb begin
    gnt_next = '0;
    gnt_next[win] = 1'b1;
    sel_dev  = '0;
    sel_mod  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_dev  = req_dev_id[i*8 +: 8];
        sel_mod  = req_mod_id[i*8 +: 8];
        sel_addr = req_addr[i*8 +: 8];
        sel_data = req_data[i*8 +: 8];
      end
    end
  end

  // Sequencer FSM; every output is a register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr       <= PW'(NREQ - 1);
      grant    <= '0;
      done     <= '0;
      err      <= '0;
      now_send <= 1'b0;
      dev_id   <= '0;
      mod_id   <= '0;
      addr     <= '0;
      data     <= '0;
      busy     <= 1'b0;
      wcnt     <= '0;
      gcnt     <= '0;
    end else begin
      done     <= '0;
      err      <= '0;
      now_send <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            rr     <= win;
            grant  <= gnt_next;
            dev_id <= sel_dev;
            mod_id <= sel_mod;
            addr   <= sel_addr;
            data   <= sel_data;
            busy   <= 1'b1;
            state  <= S_LATCH;
          end
        end
        S_LATCH: begin
          now_send <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // frame_done takes priority over a timeout on the same cycle
          if (frame_done) begin
            done  <= grant;
            grant <= '0;
            gcnt  <= '0;
            state <= S_GAP;
          end else if (wcnt == TMO_LAST) begin
            err   <= grant;
            grant <= '0;
            gcnt  <= '0;
            state <= S_GAP;
          end else begin
            wcnt <= wcnt + 20'd1;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
